// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
// The optional multiply-accumulate ops are controlled by the MDU_MADD_EN macro in mdu_iter.
package mdu_pkg;

   localparam int MDU_CTRL_W = 4;

   typedef enum logic [MDU_CTRL_W-1:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   function automatic logic op_is_signed(input mdu_op_e op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle, WIDTH cycles per divide.
// quotient/remainder/valid present the final step combinationally so the caller can write at that edge.
module mdu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             valid
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;

   logic [WIDTH:0]   shift_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] step_rem_s;
   logic [WIDTH-1:0] step_quo_s;

   // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom
   always_comb begin
      shift_s = {rem_q, quo_q[WIDTH-1]};
      diff_s  = shift_s - {1'b0, dvs_q};
      if (diff_s[WIDTH]) begin
         step_rem_s = shift_s[WIDTH-1:0];
      end else begin
         step_rem_s = diff_s[WIDTH-1:0];
      end
      step_quo_s = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
   end

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (flush) begin
         run_d = 1'b0;
      end else if (run_q) begin
         rem_d = step_rem_s;
         quo_d = step_quo_s;
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
         end
      end else if (start) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
         cnt_d = CW'(WIDTH - 1);
         run_d = 1'b1;
      end else begin
         run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign quotient  = step_quo_s;
   assign remainder = step_rem_s;
   assign valid     = run_q && (cnt_q == '0);

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO; multiplies take MULT_CYCLES, divides take WIDTH cycles.
// Define MDU_MADD_EN to build MADD/MADDU/MSUB/MSUBU; otherwise those opcodes behave as NOP.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [MDU_CTRL_W-1:0] ctrl,
   input  logic [WIDTH-1:0]      src_a,
   input  logic [WIDTH-1:0]      src_b,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      hi,
   output logic [WIDTH-1:0]      lo
);

   localparam int MCW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

   mdu_state_e         state_q, state_d;
   logic [MCW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               dz_q, dz_d;

   mdu_op_e            op_s;
   logic               sgn_s;
   logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s;
   logic               div_start_s;
   logic [WIDTH-1:0]   div_quo_s, div_rem_s;
   logic               div_valid_s;

   assign op_s    = mdu_op_e'(ctrl);
   assign sgn_s   = op_is_signed(op_s);
   assign a_ext_s = sgn_s ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
   assign b_ext_s = sgn_s ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
   assign prod_s  = a_ext_s * b_ext_s;
   assign a_mag_s = (sgn_s && src_a[WIDTH-1]) ? -src_a : src_a;
   assign b_mag_s = (sgn_s && src_b[WIDTH-1]) ? -src_b : src_b;

`ifdef MDU_MADD_EN
   logic [2*WIDTH-1:0] acc_s;
   assign acc_s = ((op_s == OP_MSUB) || (op_s == OP_MSUBU)) ? ({hi_q, lo_q} - prod_s)
                                                             : ({hi_q, lo_q} + prod_s);
`endif

   mdu_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start_s),
      .dividend  (a_mag_s),
      .divisor   (b_mag_s),
      .flush     (flush),
      .quotient  (div_quo_s),
      .remainder (div_rem_s),
      .valid     (div_valid_s)
   );

   // Priority inside a running unit: flush, then completion, then a new start
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      done_d      = 1'b0;
      negq_d      = negq_q;
      negr_d      = negr_q;
      dz_d        = dz_q;
      div_start_s = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  case (op_s)
                     OP_MULT, OP_MULTU: begin
                        res_d   = prod_s;
                        cnt_d   = MCW'(MULT_CYCLES - 1);
                        state_d = ST_MUL;
                     end
`ifdef MDU_MADD_EN
                     OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                        res_d   = acc_s;
                        cnt_d   = MCW'(MULT_CYCLES - 1);
                        state_d = ST_MUL;
                     end
`else
                     OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                        state_d = ST_IDLE;
                     end
`endif
                     OP_DIV, OP_DIVU: begin
                        div_start_s = 1'b1;
                        negq_d      = sgn_s && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        negr_d      = sgn_s && src_a[WIDTH-1];
                        dz_d        = (src_b == '0);
                        state_d     = ST_DIV;
                     end
                     OP_MTHI: hi_d = src_a;
                     OP_MTLO: lo_d = src_a;
                     default: state_d = ST_IDLE;
                  endcase
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL: begin
               if (cnt_q == '0) begin
                  {hi_d, lo_d} = res_q;
                  done_d       = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - {{(MCW-1){1'b0}}, 1'b1};
               end
            end
            ST_DIV: begin
               if (div_valid_s) begin
                  if (!dz_q) begin
                     lo_d = negq_q ? -div_quo_s : div_quo_s;
                     hi_d = negr_q ? -div_rem_s : div_rem_s;
                  end else begin
                     lo_d = lo_q;
                  end
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DIV;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: transaction-level reference model checked every cycle,
// directed cases with hand-computed results, then randomized traffic including flush and reset.
module tb_mdu_iter;

   localparam int W  = 32;
   localparam int MC = 5;

`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, flush;
   logic [3:0]    ctrl;
   logic [W-1:0]  src_a, src_b;
   logic          busy, done;
   logic [W-1:0]  hi, lo;

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(W), .MULT_CYCLES(MC)) dut (
      .clk(clk), .reset(reset), .start(start), .ctrl(ctrl),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model (whole-transaction arithmetic) ----------------
   logic [W-1:0]  m_hi = '0, m_lo = '0;
   int            m_left = 0;
   bit            m_done = 1'b0;
   bit            m_wr = 1'b0;
   logic [63:0]   m_pend = '0;

   task automatic accept(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (c)
         4'd1: begin m_pend = sa * sb; m_wr = 1'b1; m_left = MC; end
         4'd2: begin m_pend = {32'd0, a} * {32'd0, b}; m_wr = 1'b1; m_left = MC; end
         4'd3: begin
            m_wr = (b != 32'd0);
            m_left = W;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) m_pend = {32'h0, 32'h8000_0000};
            else if (b != 32'd0) begin
               q = sa / sb;
               r = sa % sb;
               m_pend = {r[31:0], q[31:0]};
            end
         end
         4'd4: begin
            m_wr = (b != 32'd0);
            m_left = W;
            if (b != 32'd0) m_pend = {a % b, a / b};
         end
         4'd5: m_hi = a;
         4'd6: m_lo = a;
         4'd7, 4'd8, 4'd9, 4'd10: begin
            if (MADD_EN) begin
               p = (c == 4'd7 || c == 4'd9) ? sa * sb : {32'd0, a} * {32'd0, b};
               m_pend = (c >= 4'd9) ? ({m_hi, m_lo} - p) : ({m_hi, m_lo} + p);
               m_wr = 1'b1;
               m_left = MC;
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
         end else begin
            m_done = 1'b0;
            if (flush) m_left = 0;
            else if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  if (m_wr) {m_hi, m_lo} = m_pend;
                  m_done = 1'b1;
               end
            end else if (start) accept(ctrl, src_a, src_b);
         end
         #1;
         chk("busy", busy, m_left > 0);
         chk("done", done, m_done);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; ctrl = c; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int ncyc, output int bcnt, output int dcnt);
      issue(c, a, b);
      bcnt = 0; dcnt = 0;
      repeat (ncyc) begin
         if (busy === 1'b1) bcnt++;
         if (done === 1'b1) dcnt++;
         @(negedge clk);
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 20));
         5: return -32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int b, d;
      bit got;
      reset = 1'b0; start = 1'b0; flush = 1'b0; ctrl = 4'd0; src_a = '0; src_b = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("reset_hi", hi, 64'h0);
      chk("reset_lo", lo, 64'h0);
      chk("reset_busy", busy, 64'h0);

      run_op(4'd1, 32'hFFFF_FFFD, 32'd7, MC + 3, b, d);
      chk("mult_busy_len", b, 64'd5);
      chk("mult_done_cnt", d, 64'd1);
      chk("mult_hi", hi, 64'hFFFF_FFFF);
      chk("mult_lo", lo, 64'hFFFF_FFEB);

      run_op(4'd2, 32'hFFFF_FFFF, 32'd2, MC + 3, b, d);
      chk("multu_hi", hi, 64'h1);
      chk("multu_lo", lo, 64'hFFFF_FFFE);

      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, W + 3, b, d);
      chk("div_busy_len", b, 64'd32);
      chk("div_lo", lo, 64'hFFFF_FFFD);
      chk("div_hi", hi, 64'hFFFF_FFFF);

      run_op(4'd4, 32'd7, 32'd0, W + 3, b, d);
      chk("divz_busy_len", b, 64'd32);
      chk("divz_lo", lo, 64'hFFFF_FFFD);
      chk("divz_hi", hi, 64'hFFFF_FFFF);

      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, W + 3, b, d);
      chk("divovf_lo", lo, 64'h8000_0000);
      chk("divovf_hi", hi, 64'h0);

      run_op(4'd6, 32'd0, 32'd0, 2, b, d);
      run_op(4'd5, 32'h1234, 32'd0, 2, b, d);
      chk("mthi_no_busy", b, 64'd0);
      run_op(4'd7, 32'd2, 32'd3, MC + 3, b, d);
`ifdef MDU_MADD_EN
      chk("madd_busy_len", b, 64'd5);
      chk("madd_hi", hi, 64'h1234);
      chk("madd_lo", lo, 64'h6);
`else
      chk("madd_off_busy", b, 64'd0);
      chk("madd_off_hi", hi, 64'h1234);
      chk("madd_off_lo", lo, 64'h0);
`endif
      run_op(4'd5, 32'd0, 32'd0, 2, b, d);
      run_op(4'd10, 32'd1, 32'd7, MC + 3, b, d);
`ifdef MDU_MADD_EN
      chk("msubu_hi", hi, 64'hFFFF_FFFF);
      chk("msubu_lo", lo, 64'hFFFF_FFF9);
`else
      chk("msubu_off_hi", hi, 64'h0);
      chk("msubu_off_lo", lo, 64'h0);
`endif

      // flush a divide at its tenth busy cycle
      run_op(4'd5, 32'hAAAA, 32'd0, 2, b, d);
      run_op(4'd6, 32'h5555, 32'd0, 2, b, d);
      issue(4'd3, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 64'h0);
      d = 0;
      repeat (W + 4) begin
         if (done === 1'b1) d++;
         @(negedge clk);
      end
      chk("flush_no_done", d, 64'd0);
      chk("flush_hi", hi, 64'hAAAA);
      chk("flush_lo", lo, 64'h5555);

      start = 1'b1; ctrl = 4'd6; src_a = 32'hDEAD; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_mtlo_lo", lo, 64'h5555);

      // back-to-back: DIVU issued in the done cycle of a MULT
      issue(4'd1, 32'd3, 32'd4);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (done === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      chk("b2b_done_seen", got, 64'd1);
      start = 1'b1; ctrl = 4'd4; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", busy, 64'h1);
      repeat (W + 2) @(negedge clk);
      chk("b2b_lo", lo, 64'd14);
      chk("b2b_hi", hi, 64'd2);

      // start while busy is ignored
      issue(4'd1, 32'd3, 32'd4);
      start = 1'b1; ctrl = 4'd5; src_a = 32'd999;
      @(negedge clk);
      start = 1'b0;
      repeat (MC + 2) @(negedge clk);
      chk("midbusy_hi", hi, 64'h0);
      chk("midbusy_lo", lo, 64'hC);

      // reset mid-operation, with a start present
      run_op(4'd5, 32'd77, 32'd0, 2, b, d);
      issue(4'd1, 32'd5, 32'd5);
      reset = 1'b0; start = 1'b1; ctrl = 4'd6; src_a = 32'd1;
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      chk("rst_hi", hi, 64'h0);
      chk("rst_lo", lo, 64'h0);
      chk("rst_busy", busy, 64'h0);
      repeat (MC + 2) @(negedge clk);
      chk("rst_abandon_lo", lo, 64'h0);

      // randomized traffic, checked every cycle by the model process
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 199) != 0);
         flush = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 2) != 0);
         ctrl  = 4'($urandom_range(0, 15));
         src_a = pick();
         src_b = pick();
      end
      @(negedge clk);
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      repeat (W + 4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
